// File: rtl/xor_misr_pkg.sv
// Shared types and helpers for the XOR-feedback signature bank.
// The step() helper works on a wide container so one definition serves every lane width.
package xor_misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest lane the shared step() helper can handle.
  localparam int MAX_W = 64;

  // Beat-counter width for the default run length of 15 beats.
  localparam int CNT_W = $clog2(15 + 1);

  // One Galois shift: shift left, fold the outgoing MSB back through the taps.
  // Only bits [width-1:0] of the result are meaningful.
  function automatic logic [MAX_W-1:0] step(input logic [MAX_W-1:0] s,
                                            input logic [MAX_W-1:0] poly,
                                            input int               width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < width) r[i] = s[i-1];
    end
    if (s[width-1]) r = r ^ poly;
    return r;
  endfunction

endpackage

// File: rtl/xor_misr_lane.sv
// One WIDTH-bit Galois register: loads a seed, then advances once per accepted beat
// as a free-running LFSR (mode=0) or as a MISR folding in beat data (mode=1).
module xor_misr_lane
  import xor_misr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 'h3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adv,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] seed_g;
  logic [WIDTH-1:0] nxt;

  // NOTE: every always_comb output gets a default first, so no branch can leave a latch.
  always_comb begin
    seed_g = load_val;
    // An all-zero LFSR never leaves zero; a MISR is driven by its data and may start there.
    if (!mode && load_val == '0) seed_g = WIDTH'(1);
    nxt = WIDTH'(step(MAX_W'(state), MAX_W'(POLY), WIDTH));
    if (mode) nxt = nxt ^ data;
  end

  // NOTE: clocked state uses non-blocking (<=) so every lane samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)    state <= '0;
    else if (load) state <= seed_g;
    else if (adv)  state <= nxt;
  end

endmodule

// File: rtl/xor_misr_bank.sv
// NUM_CH independent Galois LFSR/MISR lanes sharing one run controller:
// start loads seeds, NUM_BEATS accepted beats advance the lanes, the result is held until sig_ack.
module xor_misr_bank
  import xor_misr_pkg::*;
#(
  parameter int               NUM_CH       = 3,
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] POLY         = 'h3,
  parameter int               NUM_BEATS    = 15,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 'h1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  seed_sel,
  input  logic [NUM_CH-1:0][WIDTH-1:0]          seed,
  input  logic                                  mode,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_CH-1:0][WIDTH-1:0]          in_data,
  output logic [NUM_CH-1:0][WIDTH-1:0]          sig_out,
  output logic                                  sig_valid,
  input  logic                                  sig_ack,
  output logic                                  busy,
  output logic [$clog2(NUM_BEATS+1)-1:0]        beat_cnt
);

  localparam int CW = $clog2(NUM_BEATS + 1);

  state_e state;
  logic   mode_q;
  logic   accept;
  logic   lane_mode;

  // A beat offered in the same cycle as start is dropped: the restart takes priority.
  assign accept    = in_valid & in_ready & ~start;
  assign lane_mode = start ? mode : mode_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    xor_misr_lane #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start),
      .load_val (seed_sel ? seed[ch] : SEED_DEFAULT),
      .adv      (accept),
      .mode     (lane_mode),
      .data     (in_data[ch]),
      .state    (sig_out[ch])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      beat_cnt  <= '0;
      in_ready  <= 1'b0;
      sig_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (start) begin
      state     <= RUN;
      mode_q    <= mode;
      beat_cnt  <= '0;
      in_ready  <= 1'b1;
      sig_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (beat_cnt != CW'(NUM_BEATS)) beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CW'(NUM_BEATS - 1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              sig_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (sig_ack) begin
            state     <= IDLE;
            sig_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_misr_bank.sv
// Randomized scoreboard bench for xor_misr_bank: a driver updates a polynomial-arithmetic
// model and queues expected states; a monitor compares them whenever the DUT accepts a beat.
module tb_xor_misr_bank;

  localparam int         NUM_CH       = 3;
  localparam int         WIDTH        = 4;
  localparam logic [3:0] POLY         = 4'h3;
  localparam int         NUM_BEATS    = 15;
  localparam logic [3:0] SEED_DEFAULT = 4'h1;
  localparam int         CW           = $clog2(NUM_BEATS + 1);

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic                         seed_sel = 1'b0;
  logic [NUM_CH-1:0][WIDTH-1:0] seed = '0;
  logic                         mode = 1'b0;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [NUM_CH-1:0][WIDTH-1:0] in_data = '0;
  logic [NUM_CH-1:0][WIDTH-1:0] sig_out;
  logic                         sig_valid;
  logic                         sig_ack = 1'b0;
  logic                         busy;
  logic [CW-1:0]                beat_cnt;

  xor_misr_bank #(
    .NUM_CH       (NUM_CH),
    .WIDTH        (WIDTH),
    .POLY         (POLY),
    .NUM_BEATS    (NUM_BEATS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed_sel  (seed_sel),
    .seed      (seed),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sig_out   (sig_out),
    .sig_valid (sig_valid),
    .sig_ack   (sig_ack),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned sig [NUM_CH];
    int unsigned cnt;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: lane values as polynomials over GF(2) modulo x^WIDTH + POLY.
  int unsigned m_sig [NUM_CH];
  int unsigned m_cnt;
  bit          m_run, m_done, m_mode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Multiply by x and reduce modulo the characteristic polynomial.
  function automatic int unsigned mul_x(input int unsigned s);
    int unsigned r;
    r = s << 1;
    if (r >= (32'd1 << WIDTH)) r = r ^ ((32'd1 << WIDTH) | 32'(POLY));
    return r;
  endfunction

  // Monitor: whenever the DUT takes a beat, the next queued expectation must appear.
  always @(posedge clk) begin
    bit   acc;
    exp_t e;
    acc = (rst_n === 1'b1) && (start === 1'b0) && (in_valid === 1'b1) && (in_ready === 1'b1);
    if (acc) begin
      #1;
      if (exp_q.size() == 0) begin
        check("unexpected_beat_accept", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        for (int ch = 0; ch < NUM_CH; ch++)
          check($sformatf("beat_sig_ch%0d", ch), 64'(sig_out[ch]), 64'(e.sig[ch]));
        check("beat_cnt", 64'(beat_cnt), 64'(e.cnt));
        check("beat_sig_valid", 64'(sig_valid), 64'(e.last));
        check("beat_busy", 64'(busy), 64'(!e.last));
      end
    end
  end

  task automatic check_model_state(input string tag);
    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("%s_sig_ch%0d", tag, ch), 64'(sig_out[ch]), 64'(m_sig[ch]));
    check({tag, "_busy"}, 64'(busy), 64'(m_run));
    check({tag, "_sig_valid"}, 64'(sig_valid), 64'(m_done));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(m_run));
  endtask

  // All driver tasks begin and end just after a falling edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    in_data  = NUM_CH*WIDTH'($urandom);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    m_run = 0; m_done = 0; m_cnt = 0;
    foreach (m_sig[ch]) m_sig[ch] = 0;
    check_model_state("reset");
    check("reset_beat_cnt", 64'(beat_cnt), 64'd0);
  endtask

  task automatic do_start(input bit md, input bit sel,
                          input logic [NUM_CH-1:0][WIDTH-1:0] sd,
                          input bit drop_beat, input bit ack);
    start    = 1'b1;
    mode     = md;
    seed_sel = sel;
    seed     = sd;
    in_valid = drop_beat;
    in_data  = NUM_CH*WIDTH'($urandom);
    sig_ack  = ack;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_sig[ch] = sel ? 32'(sd[ch]) : 32'(SEED_DEFAULT);
      if (!md && m_sig[ch] == 0) m_sig[ch] = 1;
    end
    m_cnt = 0; m_run = 1; m_done = 0; m_mode = md;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; sig_ack = 1'b0;
    check_model_state("start");
    check("start_beat_cnt", 64'(beat_cnt), 64'd0);
  endtask

  task automatic beat(input bit valid);
    exp_t e;
    in_valid = valid;
    in_data  = NUM_CH*WIDTH'($urandom);
    if (valid && m_run) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        m_sig[ch] = mul_x(m_sig[ch]) ^ (m_mode ? 32'(in_data[ch]) : 32'd0);
      m_cnt++;
      if (m_cnt == NUM_BEATS) begin m_run = 0; m_done = 1; end
      foreach (m_sig[ch]) e.sig[ch] = m_sig[ch];
      e.cnt  = m_cnt;
      e.last = m_done;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("cycle_busy", 64'(busy), 64'(m_run));
    check("cycle_sig_valid", 64'(sig_valid), 64'(m_done));
  endtask

  task automatic do_ack();
    sig_ack = 1'b1;
    @(negedge clk);
    sig_ack = 1'b0;
    m_done = 0;
    check_model_state("ack");
  endtask

  logic [NUM_CH-1:0][WIDTH-1:0] sd;
  logic [WIDTH-1:0]             lfsr_seq [NUM_BEATS];

  initial begin
    lfsr_seq = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
    @(negedge clk);
    do_reset();

    // Full LFSR period from the default seed.
    do_start(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_BEATS; i++) begin
      beat(1'b1);
      check($sformatf("lfsr_seq_%0d", i), 64'(sig_out[0]), 64'(lfsr_seq[i]));
    end
    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("lfsr_final_ch%0d", ch), 64'(sig_out[ch]), 64'd1);
    check("lfsr_final_cnt", 64'(beat_cnt), 64'(NUM_BEATS));

    // Result must hold in DONE while data churns and no ack arrives.
    for (int i = 0; i < 10; i++) beat(1'($urandom_range(0, 1)));
    check_model_state("done_hold");
    check("done_hold_cnt", 64'(beat_cnt), 64'(NUM_BEATS));
    do_ack();

    // Zero-seed guard in LFSR mode, then the same seed in MISR mode (restart with dropped beat).
    sd = '0;
    sd[0] = 4'h5; sd[2] = 4'h9;
    do_start(1'b0, 1'b1, sd, 1'b0, 1'b0);
    check("zero_guard_load", 64'(sig_out[1]), 64'd1);
    beat(1'b1);
    check("zero_guard_step", 64'(sig_out[1]), 64'd2);
    do_start(1'b1, 1'b1, sd, 1'b1, 1'b0);
    check("misr_zero_load", 64'(sig_out[1]), 64'd0);

    // Restart after five beats, then abort mid-run with reset.
    for (int i = 0; i < 5; i++) beat(1'b1);
    check("pre_restart_cnt", 64'(beat_cnt), 64'd5);
    do_start(1'b1, 1'b1, sd, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) beat(1'($urandom_range(0, 1)));
    do_reset();

    // Randomized runs with handshake gaps, restarts, aborts and start-beats-ack.
    for (int r = 0; r < 16; r++) begin
      int  budget;
      bit  ack_with_start;
      for (int ch = 0; ch < NUM_CH; ch++)
        sd[ch] = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      ack_with_start = m_done && (r % 2 == 1);
      do_start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sd,
               1'($urandom_range(0, 1)), ack_with_start);
      budget = 0;
      while (!m_done && budget < 200) begin
        beat($urandom_range(0, 99) < 60);
        budget++;
        if (m_cnt == 5 && r % 4 == 1 && budget < 100) begin
          do_start(m_mode, 1'b1, sd, 1'b1, 1'b0);
          budget = 100;
        end
        if (m_cnt == 7 && r % 8 == 2) begin
          do_reset();
          break;
        end
      end
      if (budget >= 200) check("run_budget_expired", 64'd1, 64'd0);
      if (m_done) begin
        check_model_state("run_done");
        check("run_done_cnt", 64'(beat_cnt), 64'(NUM_BEATS));
        if (r % 2 == 0) do_ack();
      end
    end

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
